// File: rtl/sar_adc_pkg.sv
// Shared types and default constants for the SAR ADC controller.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_e;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SAMPLE_CYCLES = 4;

endpackage

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// 2-flop synchronizer for the asynchronous comparator output.
// Only built when SAR_ADC_CTRL_CMP_SYNC_EN is defined; the default build
// samples the comparator directly and carries no synchronizer flops.
`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
module cmp_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops, both cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track phase, MSB-first binary
// search on the feedback DAC, then a valid/ready result handshake.
// Option macro SAR_ADC_CTRL_CMP_SYNC_EN: synchronize cmp_in through two
// flops and stretch every trial to 3 clocks so the decision sees a settled,
// synchronized comparator value.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             busy,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int               IW      = $clog2(WIDTH);
  localparam logic [7:0]       SC_LOAD = 8'(SAMPLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [IW-1:0]    TOP     = IW'(WIDTH - 1);

  sar_state_e       state;
  logic [7:0]       smp_cnt;
  logic [IW-1:0]    bit_idx;
  logic             cmp_d;
  logic             trial_end;
  logic [WIDTH-1:0] decided;

`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
  logic [1:0] tr_cnt;

  cmp_sync u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (cmp_d)
  );

  // Decision only on the third cycle of a trial, when the synchronizer
  // output reflects the comparator during this trial code
  assign trial_end = (tr_cnt == 2'd2);
`else
  assign cmp_d     = cmp_in;
  assign trial_end = 1'b1;
`endif

  // Current trial code with bit i kept (cmp=1) or cleared (cmp=0)
  always_comb begin
    decided = dac_code;
    if (!cmp_d) decided = dac_code & ~(ONE << bit_idx);
  end

  // Control FSM; every output is a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      sample_en    <= 1'b0;
      dac_code     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      smp_cnt      <= '0;
      bit_idx      <= '0;
`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
      tr_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SAMPLE;
            busy      <= 1'b1;
            sample_en <= 1'b1;
            smp_cnt   <= SC_LOAD;
          end
        end
        SAMPLE: begin
          if (smp_cnt == 8'd0) begin
            state     <= CONVERT;
            sample_en <= 1'b0;
            bit_idx   <= TOP;
            dac_code  <= ONE << TOP;
`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
            tr_cnt    <= '0;
`endif
          end else begin
            smp_cnt <= smp_cnt - 8'd1;
          end
        end
        CONVERT: begin
          if (trial_end) begin
`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
            tr_cnt <= '0;
`endif
            if (bit_idx == '0) begin
              state        <= DONE;
              busy         <= 1'b0;
              dac_code     <= decided;
              result       <= decided;
              result_valid <= 1'b1;
            end else begin
              dac_code <= decided | (ONE << (bit_idx - 1'b1));
              bit_idx  <= bit_idx - 1'b1;
            end
          end
`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
          else begin
            tr_cnt <= tr_cnt + 2'd1;
          end
`endif
        end
        DONE: begin
          // start is deliberately not looked at here, even on the handshake cycle
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            dac_code     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl (WIDTH=8, SAMPLE_CYCLES=4) with an
// ideal comparator cmp_in = (vin >= dac_code).
module tb_sar_adc_ctrl;

  localparam int W = 8;
  localparam int S = 4;
`ifdef SAR_ADC_CTRL_CMP_SYNC_EN
  localparam int TRIAL = 3;
`else
  localparam int TRIAL = 1;
`endif
  localparam int LAT = S + TRIAL * W;

  logic         clk, rst, start, cmp_in, result_ready;
  logic         busy, sample_en, result_valid;
  logic [W-1:0] dac_code, result;
  logic [W-1:0] vin;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] vin;
    logic [W-1:0] exp;
    bit           seq;
  } vec_t;
  vec_t tbl[6];

  logic [W-1:0] a5_seq[8];

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cmp_in       (cmp_in),
    .busy         (busy),
    .sample_en    (sample_en),
    .dac_code     (dac_code),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  assign cmp_in = (vin >= dac_code);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted result is matched against the queued expectation
  always @(negedge clk) begin
    if (!rst && result_valid === 1'b1 && result_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(result), -1);
      end else begin
        chk("sb_result", int'(result), int'(exp_q.pop_front()));
      end
    end
  end

  // Called at a negedge; returns at a negedge
  task automatic run_conv(input logic [W-1:0] v, input logic [W-1:0] e, input bit chk_seq);
    int n, busy_cnt;
    bit got;
    logic [W-1:0] tr[$];
    vin = v;
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (busy === 1'b1 && sample_en === 1'b0) tr.push_back(dac_code);
      if (busy === 1'b1) busy_cnt++;
      if (result_valid === 1'b1) got = 1'b1;
    end
    if (!got) chk("timeout_result_valid", 0, 1);
    else      chk("latency", n, LAT);
    chk("busy_cycles", busy_cnt, LAT);
    chk("dac_holds_final", int'(dac_code), int'(e));
    if (chk_seq) begin
      chk("trial_count", tr.size(), 8 * TRIAL);
      if (tr.size() == 8 * TRIAL)
        for (int k = 0; k < 8 * TRIAL; k++)
          chk($sformatf("trial_%0d", k), int'(tr[k]), int'(a5_seq[k / TRIAL]));
    end
    @(posedge clk); #1;
    chk("valid_pulse_low", int'(result_valid), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_dac", int'(dac_code), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 1'b1};
    tbl[1] = '{8'h00, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b0};
    tbl[3] = '{8'h01, 8'h01, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0};
    tbl[5] = '{8'h7F, 8'h7F, 1'b0};
    a5_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    rst = 1'b0; start = 1'b0; result_ready = 1'b1; vin = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_sample_en", int'(sample_en), 0);
    chk("rst_dac", int'(dac_code), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_valid", int'(result_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // First start lands on the very first edge after reset release
    for (int i = 0; i < 6; i++) run_conv(tbl[i].vin, tbl[i].exp, tbl[i].seq);

    // Consumer stall in DONE with start pulses that must be ignored
    vin = 8'h5A;
    result_ready = 1'b0;
    start = 1'b1;
    exp_q.push_back(8'h5A);
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (result_valid !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("stall_latency", n, LAT);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_valid", int'(result_valid), 1);
      chk("stall_result", int'(result), 8'h5A);
      chk("stall_busy", int'(busy), 0);
      start = k[0];
    end
    @(posedge clk); #1;
    result_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs_valid_low", int'(result_valid), 0);
    chk("hs_busy", int'(busy), 0);
    chk("hs_sample_en", int'(sample_en), 0);
    chk("hs_result_kept", int'(result), 8'h5A);
    @(posedge clk); #1;
    chk("hs_start_ignored", int'(busy), 0);
    @(negedge clk);

    // Reset during the bit-4 trial discards the conversion
    vin = 8'h77;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (S + 3 * TRIAL) @(posedge clk);
    #1;
    chk("bit4_trial", int'(dac_code), 8'h70);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_sample_en", int'(sample_en), 0);
    chk("mid_rst_dac", int'(dac_code), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_valid", int'(result_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_valid", int'(result_valid), 0);
      chk("post_rst_busy", int'(busy), 0);
    end
    @(negedge clk);
    run_conv(8'h3C, 8'h3C, 1'b0);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
